// File: rtl/seq_mem_req_ctrl.sv
// Request/response front end for a sequential memory with a registered read
// port. It handles one request at a time and applies bounds and timeout checks.
module seq_mem_req_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 6,
  parameter int unsigned IDX_SIZE = 4,
  parameter int unsigned TIMEOUT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [IDX_SIZE-1:0] req_addr,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WIDTH-1:0]    resp_rdata,
  output logic                resp_err,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_in,
  output logic                mem_read_en,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  input  logic                mem_write_done
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [IDX_SIZE-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the done that matches the captured direction counts; the other is ignored.
  assign done_match = write_q ? mem_write_done : mem_read_done;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (32'(req_addr) >= SIZE) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_read_en  = ~write_q;
        mem_write_en = write_q;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (done_match) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : mem_out;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr0  = addr_q;
  assign mem_in     = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_seq_mem_req_ctrl.sv
// Directed vector bench for seq_mem_req_ctrl with a behavioural sequential memory
// whose done timing can be stalled, swapped or delayed per vector.
module tb_seq_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_addr0;
  logic [31:0] mem_in;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_out;
  logic        mem_read_done, mem_write_done;

  always #5 clk = ~clk;

  seq_mem_req_ctrl #(.WIDTH(32), .SIZE(6), .IDX_SIZE(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr0(mem_addr0), .mem_in(mem_in),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_out(mem_out),
    .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
  );

  // Memory model modes: 0 normal, 1 no done, 2 opposite done, 3 done one cycle late.
  int          mem_mode = 0;
  logic [31:0] mem [16] = '{default: '0};
  logic        rd1 = 1'b0, wr1 = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [3:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(posedge clk) begin
    rd1 <= mem_read_en;
    wr1 <= mem_write_en;
    if (mem_write_en) mem[mem_addr0] <= mem_in;
    if (mem_read_en)  mem_out <= mem[mem_addr0];
    case (mem_mode)
      1:       begin mem_read_done <= 1'b0;         mem_write_done <= 1'b0;        end
      2:       begin mem_read_done <= mem_write_en; mem_write_done <= mem_read_en; end
      3:       begin mem_read_done <= rd1;          mem_write_done <= wr1;         end
      default: begin mem_read_done <= mem_read_en;  mem_write_done <= mem_write_en; end
    endcase
    if (mem_read_en)  begin rd_cnt = rd_cnt + 1; last_rd_addr = mem_addr0; end
    if (mem_write_en) begin wr_cnt = wr_cnt + 1; last_wr_addr = mem_addr0; last_wr_data = mem_in; end
    if (mem_read_en && mem_write_en) both_cnt = both_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          mode;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [13];

  // Issues one request and returns the latency from the accept edge to resp_valid.
  task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                       output int lat);
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    int lat, rd0, wr0;
    logic [31:0] rsnap;
    logic        esnap;
    logic        ok;

    vecs[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 0, 0, 1'b0, 32'h0,        3, 0, 1};
    vecs[1]  = '{1'b0, 4'd3,  32'h0,        0, 5, 1'b0, 32'hDEADBEEF, 3, 1, 0};
    vecs[2]  = '{1'b0, 4'd6,  32'h0,        0, 0, 1'b1, 32'h0,        1, 0, 0};
    vecs[3]  = '{1'b0, 4'd15, 32'h0,        0, 0, 1'b1, 32'h0,        1, 0, 0};
    vecs[4]  = '{1'b1, 4'd5,  32'hA5A5A5A5, 0, 2, 1'b0, 32'h0,        3, 0, 1};
    vecs[5]  = '{1'b0, 4'd5,  32'h0,        0, 0, 1'b0, 32'hA5A5A5A5, 3, 1, 0};
    vecs[6]  = '{1'b1, 4'd6,  32'h11111111, 0, 0, 1'b1, 32'h0,        1, 0, 0};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,        0, 0, 1'b0, 32'h0,        3, 1, 0};
    vecs[8]  = '{1'b0, 4'd3,  32'h0,        1, 0, 1'b1, 32'h0,        6, 1, 0};
    vecs[9]  = '{1'b1, 4'd4,  32'hCAFEF00D, 2, 0, 1'b1, 32'h0,        6, 0, 1};
    vecs[10] = '{1'b0, 4'd4,  32'h0,        0, 0, 1'b0, 32'hCAFEF00D, 3, 1, 0};
    vecs[11] = '{1'b0, 4'd3,  32'h0,        2, 1, 1'b1, 32'h0,        6, 1, 0};
    vecs[12] = '{1'b0, 4'd3,  32'h0,        3, 0, 1'b0, 32'hDEADBEEF, 4, 1, 0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready",  {63'd0, req_ready},  64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err",   {63'd0, resp_err},   64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_mem_addr0",  {60'd0, mem_addr0},  64'd0);
    chk("rst_mem_in",     {32'd0, mem_in},     64'd0);
    chk("rst_mem_en",     {62'd0, mem_read_en, mem_write_en}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      mem_mode = vecs[i].mode;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_resp_valid", i), {63'd0, resp_valid}, 64'd1);
      chk($sformatf("v%0d_resp_err", i), {63'd0, resp_err}, {63'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_resp_rdata", i), {32'd0, resp_rdata}, {32'd0, vecs[i].exp_rdata});
      rsnap = resp_rdata;
      esnap = resp_err;
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_hold%0d", i, h),
            {30'd0, resp_valid, req_ready, resp_err, resp_rdata},
            {30'd0, 1'b1, 1'b0, esnap, rsnap});
      end
      @(negedge clk) resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      chk($sformatf("v%0d_back_idle", i), {62'd0, resp_valid, req_ready}, 64'd1);
      chk($sformatf("v%0d_rd_pulses", i), 64'(rd_cnt - rd0), 64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_wr_pulses", i), 64'(wr_cnt - wr0), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_wr == 1)
        chk($sformatf("v%0d_wr_addr_data", i), {28'd0, last_wr_addr, last_wr_data},
            {28'd0, vecs[i].addr, vecs[i].wdata});
      if (vecs[i].exp_rd == 1)
        chk($sformatf("v%0d_rd_addr", i), {60'd0, last_rd_addr}, {60'd0, vecs[i].addr});
    end

    // Reset lands in WAIT of a write whose done arrives the cycle after reset.
    @(negedge clk);
    mem_mode = 3;
    wr0 = wr_cnt;
    chk("rstw_req_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rstw_ready_after", {63'd0, req_ready}, 64'd1);
    chk("rstw_addr_data_clr", {28'd0, mem_addr0, mem_in}, 64'd0);
    chk("rstw_wr_pulses", 64'(wr_cnt - wr0), 64'd1);
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("rstw_no_response", {63'd0, ok}, 64'd1);

    @(negedge clk) mem_mode = 0;
    issue(1'b0, 4'd3, 32'h0, lat);
    chk("post_rst_latency", 64'(lat), 64'd3);
    chk("post_rst_rdata", {31'd0, resp_err, resp_rdata}, {31'd0, 1'b0, 32'hDEADBEEF});
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;

    chk("never_both_enables", 64'(both_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mem_req_ctrl.md
SEQ_MEM_REQ_CTRL -- requirements
Module: seq_mem_req_ctrl

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, meaning the data word width.
REQ-002 The block SHALL take parameter SIZE, default 6, meaning the number of valid memory words.
REQ-003 The block SHALL take parameter IDX_SIZE, default 4, meaning the address width.
REQ-004 The block SHALL take parameter TIMEOUT, default 4, meaning the maximum WAIT cycles before an error response.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  1  request offered.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  IDX_SIZE  request address.
REQ-011 req_wdata  input  WIDTH  write data.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  consumer takes the response.
REQ-014 resp_rdata  output  WIDTH  read data; 0 for writes and errors.
REQ-015 resp_err  output  1  out-of-bounds address or timeout.
REQ-016 mem_addr0  output  IDX_SIZE  address to the sequential memory.
REQ-017 mem_in  output  WIDTH  write data to the memory.
REQ-018 mem_read_en / mem_write_en  output  1 each  one-cycle memory command pulses.
REQ-019 mem_out  input  WIDTH  memory registered read data.
REQ-020 mem_read_done / mem_write_done  input  1 each  memory completion, one cycle after the command.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-023 On accept, the block SHALL capture write, addr and wdata into internal registers; mem_addr0 and mem_in SHALL be driven from these registers and held stable until the next accept.
REQ-024 On accept with req_addr >= SIZE, the block SHALL go to RESP with resp_err=1 and resp_rdata=0, and SHALL issue no memory command.
REQ-025 On accept with an in-range address, the block SHALL go to ISSUE.
REQ-026 In ISSUE, exactly one of mem_read_en or mem_write_en SHALL be 1, per the captured write flag, for exactly one cycle; the FSM then goes to WAIT.
REQ-027 mem_read_en and mem_write_en SHALL be 0 in every state other than ISSUE and SHALL never be 1 together.
REQ-028 In WAIT, the matching done (read_done for reads, write_done for writes) SHALL move the FSM to RESP; on a read, mem_out is captured into resp_rdata on that edge; on a write, resp_rdata=0; in both cases resp_err=0.
REQ-029 The non-matching done SHALL be ignored in WAIT.
REQ-030 The WAIT cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle without a matching done; when it reaches TIMEOUT, the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-031 resp_valid SHALL be 1 only in RESP; resp_rdata and resp_err SHALL be held stable while resp_valid=1 && !resp_ready.
REQ-032 On resp_valid && resp_ready, the FSM SHALL return to IDLE; the next request can be accepted one cycle later, with no back-to-back bypass.
REQ-033 Nominal read/write latency SHALL be: accept at edge N, command pulse in cycle N+1, done in cycle N+2, resp_valid from cycle N+3.
REQ-034 Out-of-range latency SHALL be: accept at edge N, resp_valid from cycle N+1.

Reset
REQ-035 With reset high at an edge, the FSM SHALL go to IDLE and resp_valid, resp_err, resp_rdata, mem_addr0, mem_in and the timeout counter SHALL be cleared to 0.
REQ-036 Reset SHALL take priority over all other inputs in any state; an in-flight operation SHALL be abandoned with no response, and any late done SHALL be ignored in IDLE.
REQ-037 After reset deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-038 Write addr=3, data=0xDEADBEEF; write_done returned one cycle after the pulse -> a single mem_write_en pulse with mem_addr0=3 and mem_in=0xDEADBEEF; resp_valid 3 cycles after accept with resp_err=0 and resp_rdata=0.
REQ-039 Read addr=3 after REQ-038, memory returning 0xDEADBEEF -> a single mem_read_en pulse; resp_rdata=0xDEADBEEF and resp_err=0.
REQ-040 Read addr=6 and addr=15 -> no mem enables; resp_valid the next cycle with resp_err=1 and resp_rdata=0.
REQ-041 Read with mem_read_done held 0 -> resp_err=1 after 4 WAIT cycles; mem_read_en pulsed exactly once.
REQ-042 resp_ready held 0 for 5 cycles on a read response -> resp_valid, resp_rdata and resp_err stable; req_ready=0 throughout; IDLE one cycle after resp_ready=1.
REQ-043 Reset asserted during WAIT of a write, with write_done arriving the following cycle -> FSM in IDLE, resp_valid never asserted, req_ready=1 once reset deasserts.
